// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op encodings and width helper for the universal shift register
package shift_pkg;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_SHL  = 2'd3;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2_p1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n) + 64'd1) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear and registered at_max flag
module sat_cnt
    import shift_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = clog2_p1(MAX)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else if (en && (cnt != MAX_V)) begin
            cnt    <= cnt_inc;
            at_max <= (cnt_inc == MAX_V);
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with load, shifts and saturating shift count
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = clog2_p1(N)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          load,
    input  logic          shiftr,
    input  logic          shiftl,
    input  logic          arith,
    input  logic          si,
    input  logic [N-1:0]  D,
    output logic [N-1:0]  Q,
    output logic          so,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [1:0]   op;
    logic [N-1:0] shr_val;
    logic [N-1:0] shl_val;
    logic [N-1:0] q_nxt;
    logic         so_nxt;
    logic         cnt_en;
    logic         cnt_clr;
    logic         shr_fill;

    assign shr_fill = arith ? Q[N-1] : si;

    generate
        if (N == 1) begin : g_narrow
            assign shr_val = shr_fill;
            assign shl_val = si;
        end else begin : g_wide
            assign shr_val = {shr_fill, Q[N-1:1]};
            assign shl_val = {Q[N-2:0], si};
        end
    endgenerate

    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (shiftr) begin
            op = OP_SHR;
        end else if (shiftl) begin
            op = OP_SHL;
        end
    end

    // Shifts are dropped once the count has saturated; load always wins.
    always_comb begin
        q_nxt   = Q;
        so_nxt  = so;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (op)
            OP_LOAD: begin
                q_nxt   = D;
                cnt_clr = 1'b1;
            end
            OP_SHR: begin
                if (!done) begin
                    q_nxt  = shr_val;
                    so_nxt = Q[0];
                    cnt_en = 1'b1;
                end
            end
            OP_SHL: begin
                if (!done) begin
                    q_nxt  = shl_val;
                    so_nxt = Q[N-1];
                    cnt_en = 1'b1;
                end
            end
            default: begin
                q_nxt = Q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            Q  <= '0;
            so <= 1'b0;
        end else begin
            Q  <= q_nxt;
            so <= so_nxt;
        end
    end

    sat_cnt #(
        .MAX (N),
        .W   (CW)
    ) u_sat_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .cnt    (cnt),
        .at_max (done)
    );

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed self-checking bench for shift_reg_univ (N=8 and N=1)
module tb_shift_reg_univ;

    logic       clk;
    logic       clr_n;
    logic       load;
    logic       shiftr;
    logic       shiftl;
    logic       arith;
    logic       si;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       so8;
    logic [3:0] cnt8;
    logic       done8;

    logic       d1;
    logic       q1;
    logic       so1;
    logic [0:0] cnt1;
    logic       done1;

    int tests_run;
    int tests_failed;

    shift_reg_univ #(.N(8)) u_dut8 (
        .clk    (clk),
        .clr_n  (clr_n),
        .load   (load),
        .shiftr (shiftr),
        .shiftl (shiftl),
        .arith  (arith),
        .si     (si),
        .D      (d8),
        .Q      (q8),
        .so     (so8),
        .cnt    (cnt8),
        .done   (done8)
    );

    shift_reg_univ #(.N(1)) u_dut1 (
        .clk    (clk),
        .clr_n  (clr_n),
        .load   (load),
        .shiftr (shiftr),
        .shiftl (shiftl),
        .arith  (arith),
        .si     (si),
        .D      (d1),
        .Q      (q1),
        .so     (so1),
        .cnt    (cnt1),
        .done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic cycle(input logic ld, input logic sr, input logic sl,
                         input logic ar, input logic s, input logic [7:0] d);
        load   = ld;
        shiftr = sr;
        shiftl = sl;
        arith  = ar;
        si     = s;
        d8     = d;
        d1     = d[0];
        @(posedge clk);
        #1;
        load   = 1'b0;
        shiftr = 1'b0;
        shiftl = 1'b0;
    endtask

    logic [7:0] exp_so_seq;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clr_n  = 1'b0;
        load   = 1'b0;
        shiftr = 1'b0;
        shiftl = 1'b0;
        arith  = 1'b0;
        si     = 1'b0;
        d8     = 8'h00;
        d1     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q8), 32'h0);
        check("rst_so", 32'(so8), 32'h0);
        check("rst_cnt", 32'(cnt8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        clr_n = 1'b1;

        // Async reset mid-shift: no clock edge between assert and check.
        cycle(1, 0, 0, 0, 0, 8'hFF);
        cycle(0, 0, 1, 0, 1, 8'h00);
        cycle(0, 1, 0, 0, 1, 8'h00);
        check("pre_rst_cnt", 32'(cnt8), 32'h2);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_q", 32'(q8), 32'h0);
        check("arst_so", 32'(so8), 32'h0);
        check("arst_cnt", 32'(cnt8), 32'h0);
        check("arst_done", 32'(done8), 32'h0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Logical shift right of B4 through all 8 positions.
        exp_so_seq = 8'b1011_0100;
        cycle(1, 0, 0, 0, 0, 8'hB4);
        check("ld_b4_q", 32'(q8), 32'hB4);
        check("ld_b4_cnt", 32'(cnt8), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 0, 0, 8'h00);
            check($sformatf("shr_so_%0d", i), 32'(so8), 32'(exp_so_seq[i]));
            check($sformatf("shr_cnt_%0d", i), 32'(cnt8), 32'(i + 1));
            if (i == 6) check("shr_done_7th", 32'(done8), 32'h0);
        end
        check("shr_q", 32'(q8), 32'h00);
        check("shr_done", 32'(done8), 32'h1);

        // Saturated: shifts are no-ops.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 1, 1, 8'h00);
        end
        cycle(0, 0, 1, 0, 1, 8'h00);
        check("sat_q", 32'(q8), 32'h00);
        check("sat_so", 32'(so8), 32'h1);
        check("sat_cnt", 32'(cnt8), 32'h8);
        check("sat_done", 32'(done8), 32'h1);

        // Load beats simultaneous shiftr, also while done; so holds across load.
        cycle(1, 1, 0, 0, 0, 8'h3C);
        check("ldsh_q", 32'(q8), 32'h3C);
        check("ldsh_cnt", 32'(cnt8), 32'h0);
        check("ldsh_done", 32'(done8), 32'h0);
        check("ldsh_so", 32'(so8), 32'h1);

        // Arithmetic shift right: 90 -> C8 -> E4 -> F2.
        cycle(1, 0, 0, 0, 0, 8'h90);
        cycle(0, 1, 0, 1, 0, 8'h00);
        check("ash1_q", 32'(q8), 32'hC8);
        cycle(0, 1, 0, 1, 0, 8'h00);
        cycle(0, 1, 0, 1, 0, 8'h00);
        check("ash_q", 32'(q8), 32'hF2);
        check("ash_so", 32'(so8), 32'h0);
        check("ash_cnt", 32'(cnt8), 32'h3);
        check("ash_done", 32'(done8), 32'h0);

        // Shift left with si=1: 81 -> 03 (so=1) -> 07 (so=0).
        cycle(1, 0, 0, 0, 0, 8'h81);
        cycle(0, 0, 1, 1, 1, 8'h00);
        check("shl1_q", 32'(q8), 32'h03);
        check("shl1_so", 32'(so8), 32'h1);
        cycle(0, 0, 1, 0, 1, 8'h00);
        check("shl2_q", 32'(q8), 32'h07);
        check("shl2_so", 32'(so8), 32'h0);
        check("shl2_cnt", 32'(cnt8), 32'h2);

        // Both shift strobes: shiftr wins, counted once.
        cycle(1, 0, 0, 0, 0, 8'h81);
        cycle(0, 1, 1, 0, 0, 8'h00);
        check("both_q", 32'(q8), 32'h40);
        check("both_so", 32'(so8), 32'h1);
        check("both_cnt", 32'(cnt8), 32'h1);

        // N=1 instance.
        cycle(1, 0, 0, 0, 0, 8'h01);
        check("n1_ld_q", 32'(q1), 32'h1);
        check("n1_ld_done", 32'(done1), 32'h0);
        cycle(0, 1, 0, 1, 0, 8'h00);
        check("n1_shr_q", 32'(q1), 32'h1);
        check("n1_shr_so", 32'(so1), 32'h1);
        check("n1_shr_cnt", 32'(cnt1), 32'h1);
        check("n1_shr_done", 32'(done1), 32'h1);
        cycle(0, 0, 1, 0, 0, 8'h00);
        check("n1_shl_q", 32'(q1), 32'h1);
        check("n1_shl_so", 32'(so1), 32'h1);
        cycle(1, 0, 0, 0, 0, 8'h01);
        cycle(0, 0, 1, 0, 0, 8'h00);
        check("n1_shl0_q", 32'(q1), 32'h0);
        check("n1_shl0_so", 32'(so1), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
